risc8_fetch: RTL and testbench
==============================

RISC8_FETCH -- requirements
Module: risc8_fetch

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on posedge clk.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-low (rst==0 at posedge clk resets).
REQ-003 SHALL have port redirect  in  1  branch/jump request; load fetch pointer from redirect_pc.
REQ-004 SHALL have port redirect_pc  in  16  new fetch address.
REQ-005 SHALL have port mem_addr  out  16  instruction-memory byte address.
REQ-006 SHALL have port mem_req  out  1  read request; held with mem_addr stable until mem_ack.
REQ-007 SHALL have port mem_ack  in  1  memory accepts request; mem_rdata valid same cycle.
REQ-008 SHALL have port mem_rdata  in  8  read byte.
REQ-009 SHALL have port out_valid  out  1  instruction bundle valid to decoder/datapath.
REQ-010 SHALL have port out_ready  in  1  consumer accepts bundle when out_valid&&out_ready.
REQ-011 SHALL have port instr  out  8  opcode byte.
REQ-012 SHALL have port imm  out  24  immediate, little-endian; unused bytes zero.
REQ-013 SHALL have port isize  out  2  immediate byte count 0..3 (datapath advances pc by isize+1).
REQ-014 SHALL have port instr_pc  out  16  address of opcode byte.

Function
REQ-015 SHALL implement FSM states F_OP (fetch opcode), F_IMM (fetch immediates), F_HOLD (bundle presented).
REQ-016 SHALL in F_OP drive mem_req=1, mem_addr=fpc; on mem_ack capture opcode into instr, instr_pc=fpc, isize=risc8_isize(mem_rdata), clear imm, fpc+=1.
REQ-017 SHALL go F_OP->F_HOLD when decoded isize==0, else F_OP->F_IMM with byte counter=0.
REQ-018 SHALL in F_IMM on each mem_ack write mem_rdata to imm[8*cnt+:8], fpc+=1, cnt+=1; go F_HOLD on the ack with cnt==isize-1.
REQ-019 SHALL assert out_valid only in F_HOLD; instr/imm/isize/instr_pc stable while out_valid && !out_ready.
REQ-020 SHALL on out_valid&&out_ready go F_HOLD->F_OP (out_valid low next cycle).
REQ-021 SHALL give latency: with mem_ack every cycle, out_valid rises isize+1 cycles after first mem_req of the instruction.
REQ-022 SHALL wrap fpc modulo 2^16 (16'hFFFF+1 -> 16'h0000), including mid-instruction.
REQ-023 SHALL on redirect (any state) next cycle: fpc=redirect_pc, state F_OP, out_valid=0, partial/held bundle and any same-cycle mem_rdata discarded.
REQ-024 SHALL give redirect priority over a same-cycle out_ready handshake; that bundle counts as not delivered.
REQ-025 SHALL permit mem_req drop without ack only on redirect or reset.

Reset
REQ-026 SHALL on rst==0: fpc=16'h0000, state F_OP, cnt=0, out_valid=0, instr=0, imm=0, isize=0, instr_pc=0, mem_req=0, prefetch register empty.
REQ-027 SHALL assert mem_req with mem_addr=16'h0000 in the first cycle after rst returns to 1.
REQ-028 SHALL abandon any in-progress fetch when reset asserts mid-operation; no bundle emitted.

Configuration
REQ-029 SHALL, with RISC8_FETCH_PREFETCH_EN defined, fetch next opcode at fpc while in F_HOLD into a one-byte prefetch register (valid bit); on handshake with prefetch valid, skip F_OP memory read and decode from register.
REQ-030 SHALL clear prefetch valid on redirect and reset.
REQ-031 SHALL, without RISC8_FETCH_PREFETCH_EN, keep mem_req=0 throughout F_HOLD.

Structure
REQ-032 SHALL place risc8_fetch_state_t enum and function risc8_isize(opcode)->2-bit in risc8_pkg, shared with decoder.
REQ-033 SHALL be a single module, no sub-modules.

Verification
REQ-034 Reset, then mem returns 8'h05 (isize 0) at 0x0000 with ack every cycle -> mem_req rises cycle 1, out_valid next cycle, instr=8'h05, imm=0, instr_pc=0.
REQ-035 3-byte-imm opcode at 0x0010, bytes 8'hAA,8'hBB,8'hCC -> imm=24'hCCBBAA, isize=3, next mem_addr=0x0014.
REQ-036 out_ready=0 for 5 cycles in F_HOLD -> outputs stable, mem_req=0 (prefetch off), one handshake only.
REQ-037 Redirect to 0x1234 during F_IMM byte 1, same-cycle ack -> no bundle emitted, next mem_addr=0x1234.
REQ-038 1-byte-imm opcode at 0xFFFF -> imm fetched from 0x0000, next opcode from 0x0001.
REQ-039 RISC8_FETCH_PREFETCH_EN defined, out_ready held 0 -> single prefetch read at fpc; after handshake, next bundle needs no opcode read; redirect in F_HOLD discards prefetch.

Source files
------------

// File: rtl/risc8_pkg.sv
// risc8_pkg: fetch FSM state type and opcode length decode, shared by fetch and decoder.
package risc8_pkg;

  typedef enum logic [1:0] {
    F_OP   = 2'd0,
    F_IMM  = 2'd1,
    F_HOLD = 2'd2
  } risc8_fetch_state_t;

  // The immediate byte count lives in the two top opcode bits.
  function automatic logic [1:0] risc8_isize(input logic [7:0] opcode);
    return opcode[7:6];
  endfunction

endpackage

// File: rtl/risc8_fetch.sv
// risc8_fetch: byte-serial instruction fetch; assembles opcode + immediates into one bundle.
// Optional RISC8_FETCH_PREFETCH_EN: prefetch the next opcode while a bundle is held.
module risc8_fetch
  import risc8_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  instr,
  output logic [23:0] imm,
  output logic [1:0]  isize,
  output logic [15:0] instr_pc
);

  risc8_fetch_state_t state_r, state_s;
  logic [15:0] fpc_r, fpc_s;
  logic [1:0]  cnt_r, cnt_s;
  logic [7:0]  instr_r, instr_s;
  logic [23:0] imm_r, imm_s;
  logic [1:0]  isize_r, isize_s;
  logic [15:0] instr_pc_r, instr_pc_s;
  logic        mem_req_r, mem_req_s;
  logic        out_valid_r, out_valid_s;
  logic        fire_s, handshake_s, load_op_s;
  logic [7:0]  op_byte_s;
  logic [15:0] op_pc_s;
`ifdef RISC8_FETCH_PREFETCH_EN
  logic        pf_valid_r, pf_valid_s;
  logic [7:0]  pf_byte_r, pf_byte_s;
  logic [15:0] pf_pc_r, pf_pc_s;
`endif

  assign mem_addr  = fpc_r;
  assign mem_req   = mem_req_r;
  assign out_valid = out_valid_r;
  assign instr     = instr_r;
  assign imm       = imm_r;
  assign isize     = isize_r;
  assign instr_pc  = instr_pc_r;

  // Next-state, bundle assembly and next request computation.
  always_comb begin
    state_s     = state_r;
    fpc_s       = fpc_r;
    cnt_s       = cnt_r;
    instr_s     = instr_r;
    imm_s       = imm_r;
    isize_s     = isize_r;
    instr_pc_s  = instr_pc_r;
    mem_req_s   = 1'b0;
    out_valid_s = 1'b0;
    load_op_s   = 1'b0;
    op_byte_s   = mem_rdata;
    op_pc_s     = fpc_r;
    fire_s      = mem_req_r & mem_ack;
    handshake_s = out_valid_r & out_ready;
`ifdef RISC8_FETCH_PREFETCH_EN
    pf_valid_s  = pf_valid_r;
    pf_byte_s   = pf_byte_r;
    pf_pc_s     = pf_pc_r;
`endif

    case (state_r)
      F_OP: begin
        if (fire_s) begin
          load_op_s = 1'b1;
          fpc_s     = fpc_r + 16'd1;
        end else begin
          state_s = F_OP;
        end
      end
      F_IMM: begin
        if (fire_s) begin
          case (cnt_r)
            2'd0:    imm_s[7:0]   = mem_rdata;
            2'd1:    imm_s[15:8]  = mem_rdata;
            2'd2:    imm_s[23:16] = mem_rdata;
            default: imm_s        = imm_r;
          endcase
          fpc_s = fpc_r + 16'd1;
          cnt_s = cnt_r + 2'd1;
          if (cnt_r == (isize_r - 2'd1)) begin
            state_s = F_HOLD;
          end else begin
            state_s = F_IMM;
          end
        end else begin
          state_s = F_IMM;
        end
      end
      F_HOLD: begin
`ifdef RISC8_FETCH_PREFETCH_EN
        // A held opcode (or one arriving this cycle) skips the F_OP read.
        if (handshake_s) begin
          if (pf_valid_r) begin
            load_op_s  = 1'b1;
            op_byte_s  = pf_byte_r;
            op_pc_s    = pf_pc_r;
            pf_valid_s = 1'b0;
          end else if (fire_s) begin
            load_op_s = 1'b1;
            fpc_s     = fpc_r + 16'd1;
          end else begin
            state_s = F_OP;
          end
        end else if (fire_s) begin
          pf_valid_s = 1'b1;
          pf_byte_s  = mem_rdata;
          pf_pc_s    = fpc_r;
          fpc_s      = fpc_r + 16'd1;
        end else begin
          state_s = F_HOLD;
        end
`else
        if (handshake_s) begin
          state_s = F_OP;
        end else begin
          state_s = F_HOLD;
        end
`endif
      end
      default: begin
        state_s = F_OP;
      end
    endcase

    if (load_op_s) begin
      instr_s    = op_byte_s;
      instr_pc_s = op_pc_s;
      isize_s    = risc8_isize(op_byte_s);
      imm_s      = 24'd0;
      cnt_s      = 2'd0;
      if (risc8_isize(op_byte_s) == 2'd0) begin
        state_s = F_HOLD;
      end else begin
        state_s = F_IMM;
      end
    end else begin
      instr_s = instr_s;
    end

    // Redirect wins over everything, including a same-cycle handshake.
    if (redirect) begin
      state_s = F_OP;
      fpc_s   = redirect_pc;
      cnt_s   = 2'd0;
`ifdef RISC8_FETCH_PREFETCH_EN
      pf_valid_s = 1'b0;
`endif
    end else begin
      fpc_s = fpc_s;
    end

    case (state_s)
      F_OP:    mem_req_s = 1'b1;
      F_IMM:   mem_req_s = 1'b1;
`ifdef RISC8_FETCH_PREFETCH_EN
      F_HOLD:  mem_req_s = ~pf_valid_s;
`else
      F_HOLD:  mem_req_s = 1'b0;
`endif
      default: mem_req_s = 1'b0;
    endcase
    out_valid_s = (state_s == F_HOLD);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= F_OP;
      fpc_r       <= 16'h0000;
      cnt_r       <= 2'd0;
      instr_r     <= 8'h00;
      imm_r       <= 24'h000000;
      isize_r     <= 2'd0;
      instr_pc_r  <= 16'h0000;
      mem_req_r   <= 1'b0;
      out_valid_r <= 1'b0;
`ifdef RISC8_FETCH_PREFETCH_EN
      pf_valid_r  <= 1'b0;
      pf_byte_r   <= 8'h00;
      pf_pc_r     <= 16'h0000;
`endif
    end else begin
      state_r     <= state_s;
      fpc_r       <= fpc_s;
      cnt_r       <= cnt_s;
      instr_r     <= instr_s;
      imm_r       <= imm_s;
      isize_r     <= isize_s;
      instr_pc_r  <= instr_pc_s;
      mem_req_r   <= mem_req_s;
      out_valid_r <= out_valid_s;
`ifdef RISC8_FETCH_PREFETCH_EN
      pf_valid_r  <= pf_valid_s;
      pf_byte_r   <= pf_byte_s;
      pf_pc_r     <= pf_pc_s;
`endif
    end
  end

endmodule

// File: tb/tb_risc8_fetch.sv
// tb_risc8_fetch: directed scenarios plus randomized traffic checked against an instruction-stream model.
module tb_risc8_fetch;

  logic        clk = 1'b0;
  logic        rst, redirect, mem_req, mem_ack, out_valid, out_ready;
  logic [15:0] redirect_pc, mem_addr, instr_pc;
  logic [7:0]  mem_rdata, instr;
  logic [23:0] imm;
  logic [1:0]  isize;
  logic [7:0]  mem [0:65535];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];

  risc8_fetch dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .imm(imm),
    .isize(isize), .instr_pc(instr_pc)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check_eq("wait_valid", out_valid, 1);
  endtask

  task automatic jump(input logic [15:0] pc);
    redirect = 1'b1; redirect_pc = pc; mem_ack = 1'b0;
    tick();
    redirect = 1'b0;
  endtask

  // Reference: the bundle that starts at pc, read straight from the memory image.
  function automatic logic [31:0] model_bundle(input logic [15:0] pc, output int n);
    logic [23:0] v;
    logic [15:0] a;
    n = int'(mem[pc]) / 64;
    v = 24'd0;
    for (int k = 1; k <= n; k++) begin
      a = pc + 16'(k);
      v = v | (24'(mem[a]) << (8 * (k - 1)));
    end
    return {mem[pc], v};
  endfunction

  int n, nf, hs;
  logic [15:0] model_pc;
  logic [31:0] expb;
  int en;
  logic pv_req, pv_ack, pv_redir, pv_valid, pv_ready;
  logic [15:0] pv_addr;
  logic [31:0] pv_bundle;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; mem_ack = 1'b0; out_ready = 1'b0;
    mem[0] = 8'h05;
    tick(); tick();
    check_eq("rst_req", mem_req, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_instr", instr, 0);
    check_eq("rst_imm", imm, 0);
    check_eq("rst_isize", isize, 0);
    check_eq("rst_ipc", instr_pc, 0);
    check_eq("rst_addr", mem_addr, 0);

    // First opcode after reset, zero-immediate.
    rst = 1'b1; mem_ack = 1'b1;
    tick();
    check_eq("first_req", mem_req, 1);
    check_eq("first_addr", mem_addr, 16'h0000);
    check_eq("first_valid", out_valid, 0);
    wait_valid(n);
    check_eq("lat0", n, 1);
    check_eq("b0_instr", instr, 8'h05);
    check_eq("b0_imm", imm, 0);
    check_eq("b0_ipc", instr_pc, 0);
    check_eq("b0_isize", isize, 0);

    // Back-pressure for five cycles.
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_valid", out_valid, 1);
      check_eq("stall_bundle", {instr, imm, instr_pc}, {8'h05, 24'h0, 16'h0});
`ifndef RISC8_FETCH_PREFETCH_EN
      check_eq("stall_noreq", mem_req, 0);
`endif
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("after_hs_valid", out_valid, 0);
    check_eq("after_hs_addr", mem_addr, 16'h0001);

    // Three-byte immediate.
    mem[16'h0010] = 8'hC0; mem[16'h0011] = 8'hAA; mem[16'h0012] = 8'hBB; mem[16'h0013] = 8'hCC;
    jump(16'h0010);
    mem_ack = 1'b1;
    check_eq("j10_addr", mem_addr, 16'h0010);
    wait_valid(n);
    check_eq("lat3", n, 4);
    check_eq("b3_instr", instr, 8'hC0);
    check_eq("b3_imm", imm, 24'hCCBBAA);
    check_eq("b3_isize", isize, 3);
    check_eq("b3_ipc", instr_pc, 16'h0010);
    mem_ack = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("b3_next_addr", mem_addr, 16'h0014);

    // Redirect while fetching immediate byte 1 with a same-cycle ack.
    mem[16'h1234] = 8'h05;
    jump(16'h0010);
    mem_ack = 1'b1;
    tick(); tick();
    check_eq("imm1_addr", mem_addr, 16'h0012);
    redirect = 1'b1; redirect_pc = 16'h1234; out_ready = 1'b1;
    tick();
    redirect = 1'b0;
    check_eq("redir_valid", out_valid, 0);
    check_eq("redir_addr", mem_addr, 16'h1234);
    check_eq("redir_req", mem_req, 1);
    wait_valid(n);
    check_eq("redir_ipc", instr_pc, 16'h1234);
    mem_ack = 1'b0;
    tick();
    out_ready = 1'b0;

    // Address wrap inside an instruction.
    mem[16'hFFFF] = 8'h40; mem[16'h0000] = 8'h77; mem[16'h0001] = 8'h05;
    jump(16'hFFFF);
    mem_ack = 1'b1;
    wait_valid(n);
    check_eq("wrap_lat", n, 2);
    check_eq("wrap_imm", imm, 24'h000077);
    check_eq("wrap_ipc", instr_pc, 16'hFFFF);
    check_eq("wrap_isize", isize, 1);
    mem_ack = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("wrap_next_addr", mem_addr, 16'h0001);

`ifdef RISC8_FETCH_PREFETCH_EN
    mem[16'h0020] = 8'h05; mem[16'h0021] = 8'h05; mem[16'h0022] = 8'h05; mem[16'h0030] = 8'h05;
    jump(16'h0020);
    mem_ack = 1'b1;
    wait_valid(n);
    nf = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req && mem_ack) nf++;
      tick();
    end
    check_eq("pf_reads", nf, 1);
    check_eq("pf_hold_ipc", instr_pc, 16'h0020);
    mem_ack = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("pf_valid", out_valid, 1);
    check_eq("pf_ipc", instr_pc, 16'h0021);
    mem_ack = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 16'h0030; mem_ack = 1'b0;
    tick();
    redirect = 1'b0;
    check_eq("pf_redir_valid", out_valid, 0);
    check_eq("pf_redir_addr", mem_addr, 16'h0030);
    mem_ack = 1'b1;
    wait_valid(n);
    check_eq("pf_redir_ipc", instr_pc, 16'h0030);
    mem_ack = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("pf_discarded", out_valid, 0);
`endif

    // Reset in the middle of an instruction.
    jump(16'h0010);
    mem_ack = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check_eq("midrst_valid", out_valid, 0);
    check_eq("midrst_req", mem_req, 0);
    check_eq("midrst_instr", instr, 0);
    rst = 1'b1;

    // Randomized traffic against the stream model.
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst = 1'b0; mem_ack = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b1;
    model_pc = 16'h0000;
    hs = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0 && pv_req && !pv_ack && !pv_redir) begin
        check_eq("rnd_req_hold", mem_req, 1);
        check_eq("rnd_addr_hold", mem_addr, pv_addr);
      end
      if (c > 0 && pv_valid && !pv_ready && !pv_redir) begin
        check_eq("rnd_valid_hold", out_valid, 1);
        check_eq("rnd_bundle_hold", {instr, imm}, pv_bundle);
      end
`ifndef RISC8_FETCH_PREFETCH_EN
      if (out_valid) check_eq("rnd_hold_noreq", mem_req, 0);
`endif
      redirect    = ($urandom_range(0, 31) == 0);
      redirect_pc = 16'($urandom);
      mem_ack     = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      if (redirect) begin
        model_pc = redirect_pc;
      end else if (out_valid && out_ready) begin
        expb = model_bundle(model_pc, en);
        check_eq("rnd_instr", instr, expb[31:24]);
        check_eq("rnd_imm", imm, expb[23:0]);
        check_eq("rnd_isize", isize, en);
        check_eq("rnd_ipc", instr_pc, model_pc);
        model_pc = model_pc + 16'(en + 1);
        hs++;
      end
      pv_req = mem_req; pv_ack = mem_ack; pv_redir = redirect;
      pv_valid = out_valid; pv_ready = out_ready; pv_addr = mem_addr;
      pv_bundle = {instr, imm};
      tick();
    end
    check_eq("rnd_handshakes", hs > 100, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
